// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready program load, then 1-cycle registered fetch.
// Optional feature macro: IMEM_RELOAD_EN (reload_req returns RUN -> LOAD).
module imem_responder #(
  parameter int data_size = 32,
  parameter int depth     = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_size-1:0] pc_addr,
  output logic [data_size-1:0] instr,
  output logic                 instr_valid,
  output logic                 misalign_err,
  output logic                 oob_err,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [data_size-1:0] load_data,
  input  logic                 load_last,
  input  logic                 reload_req,
  output logic                 core_run
);

  localparam int AW = $clog2(depth);
  localparam logic [AW-1:0] LAST_IDX = AW'(depth - 1);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t               r_state;
  logic [AW-1:0]        r_wr_ptr;
  logic                 r_load_ready;
  logic                 r_core_run;
  logic [data_size-1:0] r_instr;
  logic                 r_instr_valid;
  logic                 r_misalign;
  logic                 r_oob;
  logic [data_size-1:0] r_mem [depth];

  logic          w_accept;
  logic          w_misalign;
  logic          w_oob;
  logic          w_reload;
  logic [AW-1:0] w_index;

  assign w_accept   = (r_state == S_LOAD) && r_load_ready && load_valid;
  assign w_index    = pc_addr[AW+1:2];
  assign w_misalign = |pc_addr[1:0];
  assign w_oob      = |pc_addr[data_size-1:AW+2];

`ifdef IMEM_RELOAD_EN
  assign w_reload = reload_req;
`else
  assign w_reload = reload_req & 1'b0;
`endif

  // Memory has no reset: contents survive reset and are only overwritten by a new load.
  always_ff @(posedge clk) begin
    if (reset && w_accept) begin
      r_mem[r_wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_LOAD;
      r_wr_ptr      <= '0;
      r_load_ready  <= 1'b0;
      r_core_run    <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_oob         <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_load_ready  <= 1'b1;
          r_instr_valid <= 1'b0;
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (load_last || (r_wr_ptr == LAST_IDX)) begin
              r_state      <= S_RUN;
              r_load_ready <= 1'b0;
              r_core_run   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_reload) begin
            r_state       <= S_LOAD;
            r_wr_ptr      <= '0;
            r_load_ready  <= 1'b1;
            r_core_run    <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_oob         <= 1'b0;
          end else begin
            r_instr_valid <= 1'b1;
            r_misalign    <= w_misalign;
            r_oob         <= w_oob;
            r_instr       <= (w_misalign || w_oob) ? '0 : r_mem[w_index];
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign misalign_err = r_misalign;
  assign oob_err      = r_oob;
  assign load_ready   = r_load_ready;
  assign core_run     = r_core_run;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: load handshake, fetch, error flags, auto-termination, mid-load reset.
module tb_imem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] pc_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_err;
  logic        oob_err;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        reload_req;
  logic        core_run;

  int unsigned checks = 0;
  int unsigned errors = 0;

  imem_responder #(.data_size(32), .depth(256)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .instr(instr),
    .instr_valid(instr_valid), .misalign_err(misalign_err), .oob_err(oob_err),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .reload_req(reload_req), .core_run(core_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                       input logic mis, input logic oob);
    pc_addr = addr;
    step();
    chk({tag, "_instr"}, instr, exp);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_mis"}, {31'd0, misalign_err}, {31'd0, mis});
    chk({tag, "_oob"}, {31'd0, oob_err}, {31'd0, oob});
  endtask

  function automatic logic [31:0] fw(input int unsigned i);
    return 32'h1000_0000 + i * 32'h0001_0001;
  endfunction

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0007;
    prog[2] = 32'h0109_5020;
    prog[3] = 32'hAC0A_0000;
    reset = 1'b0; pc_addr = '0; load_valid = 1'b0; load_data = '0;
    load_last = 1'b0; reload_req = 1'b0;

    // Reset state
    step(); step();
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_oob", {31'd0, oob_err}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_run", {31'd0, core_run}, 32'd0);

    // load_valid presented on the first edge after release must not be taken (ready still 0)
    reset = 1'b1; load_valid = 1'b1; load_data = 32'hBAD0_BAD0;
    step();
    chk("ready_rise", {31'd0, load_ready}, 32'd1);
    chk("run_low0", {31'd0, core_run}, 32'd0);

    // Four-word program, load_last on the fourth
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
      step();
      if (i < 3) chk("load_run_low", {31'd0, core_run}, 32'd0);
    end
    chk("load_done_run", {31'd0, core_run}, 32'd1);
    chk("load_done_ready", {31'd0, load_ready}, 32'd0);
    chk("load_done_valid", {31'd0, instr_valid}, 32'd0);
    // Held valid after the final accept must be ignored
    load_data = 32'hFFFF_FFFF; load_last = 1'b0;

    fetch("f0", 32'h0, prog[0], 1'b0, 1'b0);
    load_valid = 1'b0;
    fetch("f4", 32'h4, prog[1], 1'b0, 1'b0);
    fetch("f8", 32'h8, prog[2], 1'b0, 1'b0);
    fetch("fC", 32'hC, prog[3], 1'b0, 1'b0);
    fetch("f6", 32'h6, 32'h0, 1'b1, 1'b0);
    fetch("f4b", 32'h4, prog[1], 1'b0, 1'b0);
    fetch("f400", 32'h400, 32'h0, 1'b0, 1'b1);
    fetch("f402", 32'h402, 32'h0, 1'b1, 1'b1);
    fetch("f3", 32'h3, 32'h0, 1'b1, 1'b0);

`ifdef IMEM_RELOAD_EN
    reload_req = 1'b1; pc_addr = 32'h0;
    step();
    reload_req = 1'b0;
    chk("reload_run", {31'd0, core_run}, 32'd0);
    chk("reload_ready", {31'd0, load_ready}, 32'd1);
    chk("reload_valid", {31'd0, instr_valid}, 32'd0);
    chk("reload_instr", instr, 32'h0);
    chk("reload_mis", {31'd0, misalign_err}, 32'd0);
`else
    reload_req = 1'b1;
    fetch("noreload", 32'h0, prog[0], 1'b0, 1'b0);
    chk("noreload_run", {31'd0, core_run}, 32'd1);
    reload_req = 1'b0;
`endif

    // Full 256-word load with gaps, load_last never asserted
    reset = 1'b0; step();
    chk("rst2_run", {31'd0, core_run}, 32'd0);
    chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b1; step();
    for (int unsigned i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = fw(i); load_last = 1'b0;
      step();
      if (i == 254) chk("full_run_254", {31'd0, core_run}, 32'd0);
      if (i < 255) begin
        load_valid = 1'b0; load_data = 32'hDEAD_BEEF;
        step();
      end
    end
    chk("full_run_255", {31'd0, core_run}, 32'd1);
    chk("full_ready_255", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b1; load_data = 32'h5555_AAAA;
    fetch("full3FC", 32'h3FC, fw(255), 1'b0, 1'b0);
    load_valid = 1'b0;
    fetch("full000", 32'h000, fw(0), 1'b0, 1'b0);
    fetch("full004", 32'h004, fw(1), 1'b0, 1'b0);
    fetch("full200", 32'h200, fw(128), 1'b0, 1'b0);
    fetch("full3F8", 32'h3F8, fw(254), 1'b0, 1'b0);

    // Reset mid-load after two words, then a three-word reload
    reset = 1'b0; step();
    reset = 1'b1; step();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 32'h7777_0000 + 32'(i);
      step();
    end
    load_valid = 1'b0; reset = 1'b0;
    step();
    chk("midrst_ready", {31'd0, load_ready}, 32'd0);
    chk("midrst_run", {31'd0, core_run}, 32'd0);
    reset = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = 32'hCAFE_0000 + 32'(i); load_last = (i == 2);
      step();
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("reload3_run", {31'd0, core_run}, 32'd1);
    fetch("r3_0", 32'h0, 32'hCAFE_0000, 1'b0, 1'b0);
    fetch("r3_4", 32'h4, 32'hCAFE_0001, 1'b0, 1'b0);
    fetch("r3_8", 32'h8, 32'hCAFE_0002, 1'b0, 1'b0);
    fetch("r3_C", 32'hC, fw(3), 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
